// File: rtl/id_ex_stage_reg_if.sv
// ID-side decoded instruction, EX-side registered copy and the IF/ID stall request.
interface id_ex_stage_reg_if #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int ALUC_W = 4
);
  logic              validD;
  logic [RA_W-1:0]   rs1D, rs2D, rdD;
  logic              regwriteD, isloadD, memwriteD, alusrcD;
  logic [ALUC_W-1:0] alucontrolD;
  logic [XLEN-1:0]   rd1D, rd2D, immD, pcD;
  logic              flushE;

  logic              validE;
  logic [RA_W-1:0]   rs1E, rs2E, rdE;
  logic              regwriteE, isloadE, memwriteE, alusrcE;
  logic [ALUC_W-1:0] alucontrolE;
  logic [XLEN-1:0]   rd1E, rd2E, immE, pcE;
  logic              stallF, stallD;

  modport master (
    output validD, rs1D, rs2D, rdD, regwriteD, isloadD, memwriteD, alusrcD,
           alucontrolD, rd1D, rd2D, immD, pcD, flushE,
    input  validE, rs1E, rs2E, rdE, regwriteE, isloadE, memwriteE, alusrcE,
           alucontrolE, rd1E, rd2E, immE, pcE, stallF, stallD
  );

  modport slave (
    input  validD, rs1D, rs2D, rdD, regwriteD, isloadD, memwriteD, alusrcD,
           alucontrolD, rd1D, rd2D, immD, pcD, flushE,
    output validE, rs1E, rs2E, rdE, regwriteE, isloadE, memwriteE, alusrcE,
           alucontrolE, rd1E, rd2E, immE, pcE, stallF, stallD
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX register, 1-cycle D->E; stalls IF/ID with bubbles while a load producing a source is in EX or MEM.
// Optional stall/bubble saturating counters under IDEX_STALL_CNT_EN.
module id_ex_stage_reg #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int ALUC_W = 4
) (
  input logic              clk,
  input logic              rst,
  id_ex_stage_reg_if.slave bus
`ifdef IDEX_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      bubble_cnt
`endif
);

  logic            ldM_v;
  logic [RA_W-1:0] ldM_rd;
  logic            hitE, hitM, stall, bubble;

  always_comb begin
    hitE = bus.validD & bus.validE & bus.isloadE & bus.regwriteE & (bus.rdE != '0) &
           ((bus.rdE == bus.rs1D) | (bus.rdE == bus.rs2D));
    hitM = bus.validD & ldM_v & (ldM_rd != '0) &
           ((ldM_rd == bus.rs1D) | (ldM_rd == bus.rs2D));
    // A taken branch must never be blocked behind a hazard it is about to squash.
    stall  = (hitE | hitM) & ~bus.flushE;
    bubble = bus.flushE | stall | ~bus.validD;
  end

  assign bus.stallF = stall;
  assign bus.stallD = stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ldM_v           <= 1'b0;
      ldM_rd          <= '0;
      bus.validE      <= 1'b0;
      bus.rs1E        <= '0;
      bus.rs2E        <= '0;
      bus.rdE         <= '0;
      bus.regwriteE   <= 1'b0;
      bus.isloadE     <= 1'b0;
      bus.memwriteE   <= 1'b0;
      bus.alusrcE     <= 1'b0;
      bus.alucontrolE <= '0;
      bus.rd1E        <= '0;
      bus.rd2E        <= '0;
      bus.immE        <= '0;
      bus.pcE         <= '0;
    end else begin
      ldM_v  <= bus.validE & bus.isloadE & bus.regwriteE;
      ldM_rd <= bus.rdE;
      if (bubble) begin
        bus.validE      <= 1'b0;
        bus.rs1E        <= '0;
        bus.rs2E        <= '0;
        bus.rdE         <= '0;
        bus.regwriteE   <= 1'b0;
        bus.isloadE     <= 1'b0;
        bus.memwriteE   <= 1'b0;
        bus.alusrcE     <= 1'b0;
        bus.alucontrolE <= '0;
        bus.rd1E        <= '0;
        bus.rd2E        <= '0;
        bus.immE        <= '0;
        bus.pcE         <= '0;
      end else begin
        bus.validE      <= 1'b1;
        bus.rs1E        <= bus.rs1D;
        bus.rs2E        <= bus.rs2D;
        bus.rdE         <= bus.rdD;
        bus.regwriteE   <= bus.regwriteD;
        bus.isloadE     <= bus.isloadD;
        bus.memwriteE   <= bus.memwriteD;
        bus.alusrcE     <= bus.alusrcD;
        bus.alucontrolE <= bus.alucontrolD;
        bus.rd1E        <= bus.rd1D;
        bus.rd2E        <= bus.rd2D;
        bus.immE        <= bus.immD;
        bus.pcE         <= bus.pcD;
      end
    end
  end

`ifdef IDEX_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if ((stall | bus.flushE) && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`else
  // No counter state in this build.
`endif

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Decode-to-execute pipeline register for the 5-stage core, with an integrated load-use hazard detector.
- Latches decoded operands and control from ID and presents them to EX as rs1E/rs2E/rdE, read data and control, which the forwarding unit and ALU consume.
- Forwarding cannot supply a load result while the load is in EX or MEM, because the MEM path forwards the ALU result, which for a load is the address.
- The block therefore stalls IF/ID and inserts bubbles until a dependent load reaches WB.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.
- ALUC_W, 4, ALU control width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- validD  in  1  ID slot holds a real instruction.
- rs1D  in  RA_W  source 1 address.
- rs2D  in  RA_W  source 2 address.
- rdD  in  RA_W  destination address.
- regwriteD  in  1  writes register file.
- isloadD  in  1  instruction is a load.
- memwriteD  in  1  instruction is a store.
- alusrcD  in  1  ALU B operand select.
- alucontrolD  in  ALUC_W  ALU operation.
- rd1D  in  XLEN  register file read data 1.
- rd2D  in  XLEN  register file read data 2.
- immD  in  XLEN  extended immediate.
- pcD  in  XLEN  PC of the ID instruction.
- flushE  in  1  taken branch/jump resolved in EX; squash the incoming instruction.
- validE, rs1E, rs2E, rdE, regwriteE, isloadE, memwriteE, alusrcE, alucontrolE, rd1E, rd2E, immE, pcE  out  (same widths as the D inputs)  registered EX copies.
- stallF  out  1  hold PC.
- stallD  out  1  hold the IF/ID register.

Behaviour:
- Reset (rst=0, async):
  - All E outputs 0, validE=0.
  - Internal MEM-shadow (ldM_v, ldM_rd) 0.
  - stallF=stallD=0.
- Internal MEM-shadow:
  - Each clock, ldM_v <= validE & isloadE & regwriteE, and ldM_rd <= rdE.
  - This mirrors the instruction now entering MEM.
- Hazard terms (combinational, on current registered state):
  - hitE = validD & validE & isloadE & regwriteE & rdE!=0 & (rdE==rs1D | rdE==rs2D).
  - hitM = validD & ldM_v & ldM_rd!=0 & (ldM_rd==rs1D | ldM_rd==rs2D).
  - stall = (hitE | hitM) & ~flushE.
  - stallF = stallD = stall.
- Register update each rising clk, in priority order:
  1. flushE=1: load a bubble. validE, regwriteE, isloadE and memwriteE are 0; rdE, rs1E and rs2E are 0; data fields are don't-care but driven 0.
  2. stall=1: load a bubble; the ID instruction is held upstream by stallD.
  3. Otherwise: capture all D inputs, with validE=validD.
  4. validD=0 captures as a bubble (all control bits 0).
- Latency:
  - Non-stalled instruction: 1 cycle from D to E.
  - Consumer of a load immediately ahead: 2 stall cycles, 2 bubbles. The consumer enters EX when the load is in WB, so the forwarding WB-load path applies.
  - Consumer one instruction behind a load: 1 stall cycle (hitM only).
  - Consumer two behind: 0 stall cycles.
- rd=0 never triggers a stall. A store with no regwrite never triggers a stall.
- Both sources matching count as one hazard; there is no extra stall.
- flushE in the same cycle as hitE/hitM: the flush wins and stall is 0. The branch target must not be blocked, and the stale ID instruction is squashed by upstream flush logic.
- Reset mid-stall: the sequence is abandoned and stall drops immediately with rst.
- No other state. The block holds no FSM beyond the shadow registers; stall cycles are emergent.

Optional Feature:
- Macro IDEX_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [31:0], reset 0.
  - Increments on every clock where stall=1.
  - Saturates at 32'hFFFF_FFFF.
  - Adds output bubble_cnt [31:0], same rules, counting cycles where a bubble is loaded due to stall or flushE.
- When undefined: neither port exists, and there is no counter logic.

Test Plan:
- Reset:
  - Stimulus: assert rst=0 mid-traffic with validD=1.
  - Response: all E outputs and stall go to 0 immediately (async). After release, the next D instruction is captured in 1 cycle.
- Load-use, distance 1:
  - Stimulus: lw r5 in E, then add r6,r5,r2 in D.
  - Response: stallF=stallD=1 for exactly 2 cycles, with validE=0 bubbles both cycles. On the third edge, rs1E=5, validE=1.
- Load-use, distance 2:
  - Stimulus: lw r5; or r9,r1,r1; sub r7,r3,r5.
  - Response: exactly 1 stall cycle when sub is in D and the lw is in the MEM-shadow.
- No-hazard cases:
  - Stimulus: lw r0,...; add r1,r0,r0. Separately, sw followed by a dependent read of its rs.
  - Response: stall never asserts; throughput is 1 instruction per cycle.
- Flush priority:
  - Stimulus: flushE=1 in the same cycle that hitM=1.
  - Response: stall=0 and the E register receives a bubble.
  - Stimulus: flushE=1 alone with validD=1.
  - Response: validE=0 next cycle.
- Counters (IDEX_STALL_CNT_EN):
  - Stimulus: run the distance-1 case 3 times.
  - Response: stall_cnt=6 and bubble_cnt=6.
  - Stimulus: preload the counters at saturation.
  - Response: they remain at 32'hFFFF_FFFF.
